// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder/subtractor: one CHUNK-bit slice per clock through a registered carry.
// Operands enter via in_valid/in_ready, results leave via out_valid/out_ready.
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic             c_r;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   sl_sum;
    logic             c_msb;
    logic             last;

    // Slice select is a decoded mux so every part-select has a constant base.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (idx == IW'(j)) begin
                a_sl = a_r[j*CHUNK +: CHUNK];
                b_sl = b_r[j*CHUNK +: CHUNK];
            end
        end
        sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c_r};
        c_msb  = sl_sum[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
        last   = (idx == IW'(N - 1));
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= op ? ~b : b;
                        c_r <= op ? 1'b1 : cin;
                        idx <= '0;
                    end
                end
                CALC: begin
                    for (int unsigned j = 0; j < N; j++) begin
                        if (idx == IW'(j)) sum[j*CHUNK +: CHUNK] <= sl_sum[CHUNK-1:0];
                    end
                    c_r <= sl_sum[CHUNK];
                    idx <= idx + IW'(1);
                    if (last) begin
                        carry    <= sl_sum[CHUNK];
                        overflow <= c_msb ^ sl_sum[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
